// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and helpers for the programmable clock divider.
//   clkdiv_state_t   : divider FSM states (IDLE, RUN)
//   CLKDIV_MIN_DIV   : smallest legal divide ratio
//   clkdiv_clamp     : maps requested ratios 0/1 to CLKDIV_MIN_DIV
//   clkdiv_high_time : high phase length ceil(D/2)
// Helpers operate on 32-bit values; callers cast to/from DIV_WIDTH (<= 32).
package clkdiv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } clkdiv_state_t;

  localparam int unsigned CLKDIV_MIN_DIV  = 2;
  localparam int unsigned CLKDIV_FN_WIDTH = 32;

  // Ratios below the minimum cannot produce both a high and a low phase.
  function automatic logic [CLKDIV_FN_WIDTH-1:0] clkdiv_clamp(
    input logic [CLKDIV_FN_WIDTH-1:0] d
  );
    if (d < CLKDIV_FN_WIDTH'(CLKDIV_MIN_DIV)) begin
      return CLKDIV_FN_WIDTH'(CLKDIV_MIN_DIV);
    end
    return d;
  endfunction

  // ceil(D/2); one extra bit keeps D = 2^32-1 from overflowing.
  function automatic logic [CLKDIV_FN_WIDTH-1:0] clkdiv_high_time(
    input logic [CLKDIV_FN_WIDTH-1:0] d
  );
    logic [CLKDIV_FN_WIDTH:0] sum;
    sum = (CLKDIV_FN_WIDTH+1)'(d) + (CLKDIV_FN_WIDTH+1)'(1);
    return sum[CLKDIV_FN_WIDTH:1];
  endfunction

endpackage

// File: rtl/clkdiv_ratio_reg.sv
// clkdiv_ratio_reg: holds the pending and active divide ratios.
//   fast_clock, rst : clock, async active-low reset
//   div_load        : strobe capturing clamp(div_value) into pending
//   div_value       : requested ratio
//   boundary        : current edge starts a new slow period
//   idle            : divider is stopped; pending ratio may apply at once
//   div_active      : ratio governing the current period (registered)
//   load_pending    : a captured ratio waits for the next boundary (registered)
module clkdiv_ratio_reg
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 fast_clock,
  input  logic                 rst,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 boundary,
  input  logic                 idle,
  output logic [DIV_WIDTH-1:0] div_active,
  output logic                 load_pending
);

  logic [DIV_WIDTH-1:0] pending_q;
  logic [DIV_WIDTH-1:0] pending_d;
  logic [DIV_WIDTH-1:0] active_d;
  logic                 load_pending_d;
  logic [DIV_WIDTH-1:0] value_clamped_c;

  assign value_clamped_c = DIV_WIDTH'(clkdiv_clamp(CLKDIV_FN_WIDTH'(div_value)));

  // Next-state: a load coinciding with a boundary bypasses pending entirely.
  always_comb begin
    pending_d      = pending_q;
    active_d       = div_active;
    load_pending_d = load_pending;
    if (boundary && div_load) begin
      active_d       = value_clamped_c;
      pending_d      = value_clamped_c;
      load_pending_d = 1'b0;
    end else begin
      if ((boundary || idle) && load_pending) begin
        active_d       = pending_q;
        load_pending_d = 1'b0;
      end
      // A later load overrides any transfer flag clear above (last write wins).
      if (div_load) begin
        pending_d      = value_clamped_c;
        load_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      pending_q    <= DIV_WIDTH'(DEFAULT_DIV);
      div_active   <= DIV_WIDTH'(DEFAULT_DIV);
      load_pending <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      div_active   <= active_d;
      load_pending <= load_pending_d;
    end
  end

endmodule

// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider: runtime-programmable integer divider of
// fast_clock with near-50% duty, a per-period tick and glitch-free ratio
// changes applied only at period boundaries.
//   fast_clock, rst : clock, async active-low reset
//   en              : run enable (level)
//   div_value       : requested ratio D (0/1 clamp to 2), DIV_WIDTH <= 32
//   div_load        : one-cycle strobe capturing div_value
//   sync_in         : (CLKDIV_SYNC_EN only) forces a boundary while running
//   slow_clock      : divided clock, high for ceil(D/2) cycles
//   slow_tick       : one-cycle pulse on the first cycle of each period
//   div_active      : ratio in use
//   load_pending    : captured ratio waiting for a boundary
// Optional feature macro: CLKDIV_SYNC_EN. DEFAULT_DIV must be >= 2.
module programmable_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 fast_clock,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_load,
`ifdef CLKDIV_SYNC_EN
  input  logic                 sync_in,
`endif
  output logic                 slow_clock,
  output logic                 slow_tick,
  output logic [DIV_WIDTH-1:0] div_active,
  output logic                 load_pending
);

  clkdiv_state_t        state_q;
  clkdiv_state_t        state_d;
  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;
  logic                 slow_clock_d;
  logic                 slow_tick_d;
  logic [DIV_WIDTH-1:0] count_next_c;
  logic [DIV_WIDTH-1:0] high_time_c;
  logic                 wrap_c;
  logic                 sync_c;
  logic                 boundary_c;
  logic                 idle_c;

`ifdef CLKDIV_SYNC_EN
  assign sync_c = sync_in;
`else
  assign sync_c = 1'b0;
`endif

  assign count_next_c = count_q + DIV_WIDTH'(1);
  assign high_time_c  = DIV_WIDTH'(clkdiv_high_time(CLKDIV_FN_WIDTH'(div_active)));
  // div_active >= 2 always, so the subtraction cannot underflow.
  assign wrap_c       = (count_q == (div_active - DIV_WIDTH'(1)));
  assign idle_c       = (state_q == IDLE);

  // Next-state and output decode; disable takes priority over any boundary.
  always_comb begin
    state_d      = state_q;
    count_d      = '0;
    slow_clock_d = 1'b0;
    slow_tick_d  = 1'b0;
    boundary_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = RUN;
          boundary_c   = 1'b1;
          slow_clock_d = 1'b1;
          slow_tick_d  = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (wrap_c || sync_c) begin
          boundary_c   = 1'b1;
          slow_clock_d = 1'b1;
          slow_tick_d  = 1'b1;
        end else begin
          count_d      = count_next_c;
          slow_clock_d = (count_next_c < high_time_c);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge fast_clock or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      slow_clock <= 1'b0;
      slow_tick  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      slow_clock <= slow_clock_d;
      slow_tick  <= slow_tick_d;
    end
  end

  clkdiv_ratio_reg #(
    .DIV_WIDTH   (DIV_WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_ratio_reg (
    .fast_clock   (fast_clock),
    .rst          (rst),
    .div_load     (div_load),
    .div_value    (div_value),
    .boundary     (boundary_c),
    .idle         (idle_c),
    .div_active   (div_active),
    .load_pending (load_pending)
  );

endmodule
